remediation_ctrl_unit: RTL and testbench

- Parametrised run-time remediation engine that sits between a design's concatenated observe/control ports and the original signal sinks.
- Holds N_RULE programmable rules. Each rule watches the observe vector for a masked pattern sustained over a threshold number of cycles.
- On trigger, a rule forces selected control bits to programmed values for a hold window, or permanently (sticky).
- Configured and inspected through a simple register interface.

---
 rtl/remediation_ctrl_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_remediation_ctrl_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remediation_ctrl_unit.sv
// remediation_ctrl_unit: run-time remediation engine placed between a design's
// observe/control ports and the original control sinks. Each of N_RULE rules
// watches a masked pattern on observe_port. Once the pattern has been present
// for a threshold number of consecutive cycles, the rule forces selected
// control bits for a hold window, or until it is reprogrammed (sticky).
module remediation_ctrl_unit #(
    parameter int OBS_W  = 40,
    parameter int CTL_W  = 38,
    parameter int N_RULE = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OBS_W-1:0]  observe_port,
    input  logic [CTL_W-1:0]  control_port_in,
    output logic [CTL_W-1:0]  control_port_out,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [7:0]        cfg_addr,
    input  logic [OBS_W-1:0]  cfg_wdata,
    output logic [OBS_W-1:0]  cfg_rdata,
    output logic [N_RULE-1:0] rule_active,
    output logic              trig_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_ACTIVE = 2'd2
    } rule_state_t;

    // Per-rule configuration
    logic [OBS_W-1:0]  match_mask  [N_RULE];
    logic [OBS_W-1:0]  match_value [N_RULE];
    logic [CTL_W-1:0]  ctl_mask    [N_RULE];
    logic [CTL_W-1:0]  ctl_value   [N_RULE];
    logic [N_RULE-1:0] rule_en;
    logic [CNT_W-1:0]  threshold   [N_RULE];
    logic [CNT_W-1:0]  hold_len    [N_RULE];

    // Per-rule run-time state
    rule_state_t       state       [N_RULE];
    rule_state_t       nxt_state   [N_RULE];
    logic [CNT_W-1:0]  run_cnt     [N_RULE];
    logic [CNT_W-1:0]  nxt_run     [N_RULE];
    logic [CNT_W-1:0]  hold_cnt    [N_RULE];
    logic [CNT_W-1:0]  nxt_hold    [N_RULE];
    logic [CNT_W-1:0]  act_cnt     [N_RULE];

    logic [N_RULE-1:0] rule_match;
    logic [N_RULE-1:0] entering;
    logic [N_RULE-1:0] cfg_hit;
    logic [N_RULE-1:0] cnt_clr;
    logic [3:0]        cfg_rule;
    logic [3:0]        cfg_field;
    logic [OBS_W-1:0]  rd_mux;
    logic [CTL_W-1:0]  ctl_ovr;

    assign cfg_rule  = cfg_addr[7:4];
    assign cfg_field = cfg_addr[3:0];

    // A threshold of zero behaves like a threshold of one
    function automatic logic [CNT_W-1:0] thr_eff(input logic [CNT_W-1:0] thr);
        return (thr == '0) ? CNT_W'(1) : thr;
    endfunction

    // Decode config writes: fields 0-4 reprogram a rule, field 5 clears its count
    always_comb begin
        cfg_hit = '0;
        cnt_clr = '0;
        for (int i = 0; i < N_RULE; i++) begin
            if (cfg_we && (cfg_rule == 4'(i))) begin
                if (cfg_field <= 4'd4) cfg_hit[i] = 1'b1;
                if (cfg_field == 4'd5) cnt_clr[i] = 1'b1;
            end
        end
    end

    // Per-rule match evaluation and next-state logic; a config write forces IDLE
    always_comb begin
        for (int i = 0; i < N_RULE; i++) begin
            rule_match[i] = rule_en[i] &&
                ((observe_port & match_mask[i]) == (match_value[i] & match_mask[i]));
            nxt_state[i] = state[i];
            nxt_run[i]   = run_cnt[i];
            nxt_hold[i]  = hold_cnt[i];
            entering[i]  = 1'b0;
            case (state[i])
                ST_IDLE: begin
                    if (rule_match[i]) begin
                        if (thr_eff(threshold[i]) == CNT_W'(1)) begin
                            nxt_state[i] = ST_ACTIVE;
                            entering[i]  = 1'b1;
                        end else begin
                            nxt_state[i] = ST_ARMING;
                            nxt_run[i]   = CNT_W'(1);
                        end
                    end
                end
                ST_ARMING: begin
                    if (!rule_match[i]) begin
                        nxt_state[i] = ST_IDLE;
                        nxt_run[i]   = '0;
                    end else if (({1'b0, run_cnt[i]} + (CNT_W+1)'(1)) ==
                                 {1'b0, thr_eff(threshold[i])}) begin
                        nxt_state[i] = ST_ACTIVE;
                        nxt_run[i]   = '0;
                        entering[i]  = 1'b1;
                    end else begin
                        nxt_run[i] = run_cnt[i] + CNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    // hold_cnt of zero marks a sticky override
                    if (hold_cnt[i] == CNT_W'(1)) begin
                        nxt_state[i] = ST_IDLE;
                        nxt_hold[i]  = '0;
                    end else if (hold_cnt[i] != '0) begin
                        nxt_hold[i] = hold_cnt[i] - CNT_W'(1);
                    end
                end
                default: begin
                    nxt_state[i] = ST_IDLE;
                    nxt_run[i]   = '0;
                    nxt_hold[i]  = '0;
                end
            endcase
            if (entering[i]) nxt_hold[i] = hold_len[i];
            if (cfg_hit[i]) begin
                nxt_state[i] = ST_IDLE;
                nxt_run[i]   = '0;
                nxt_hold[i]  = '0;
                entering[i]  = 1'b0;
            end
        end
    end

    assign trig_pulse = |entering;

    // Rule state register and saturating activation counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_RULE; i++) begin
                state[i]    <= ST_IDLE;
                run_cnt[i]  <= '0;
                hold_cnt[i] <= '0;
                act_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_RULE; i++) begin
                state[i]    <= nxt_state[i];
                run_cnt[i]  <= nxt_run[i];
                hold_cnt[i] <= nxt_hold[i];
                if (cnt_clr[i])
                    act_cnt[i] <= '0;
                else if (entering[i] && (act_cnt[i] != '1))
                    act_cnt[i] <= act_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Configuration register writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rule_en <= '0;
            for (int i = 0; i < N_RULE; i++) begin
                match_mask[i]  <= '0;
                match_value[i] <= '0;
                ctl_mask[i]    <= '0;
                ctl_value[i]   <= '0;
                threshold[i]   <= '0;
                hold_len[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N_RULE; i++) begin
                if (cfg_hit[i]) begin
                    case (cfg_field)
                        4'd0: match_mask[i]  <= cfg_wdata;
                        4'd1: match_value[i] <= cfg_wdata;
                        4'd2: ctl_mask[i]    <= cfg_wdata[CTL_W-1:0];
                        4'd3: ctl_value[i]   <= cfg_wdata[CTL_W-1:0];
                        4'd4: begin
                            rule_en[i]   <= cfg_wdata[2*CNT_W];
                            threshold[i] <= cfg_wdata[2*CNT_W-1:CNT_W];
                            hold_len[i]  <= cfg_wdata[CNT_W-1:0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Readback multiplexer; unmapped rules and fields read as zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_RULE; i++) begin
            if (cfg_rule == 4'(i)) begin
                case (cfg_field)
                    4'd0: rd_mux = match_mask[i];
                    4'd1: rd_mux = match_value[i];
                    4'd2: rd_mux = OBS_W'(ctl_mask[i]);
                    4'd3: rd_mux = OBS_W'(ctl_value[i]);
                    4'd4: rd_mux = OBS_W'({rule_en[i], threshold[i], hold_len[i]});
                    4'd5: rd_mux = OBS_W'(act_cnt[i]);
                    4'd6: rd_mux = OBS_W'(state[i]);
                    default: rd_mux = '0;
                endcase
            end
        end
    end

    // Read data register; captures pre-write contents when read and write coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cfg_rdata <= '0;
        else if (cfg_re)
            cfg_rdata <= rd_mux;
    end

    // Override merge: iterate high to low so the lowest-index active rule wins
    always_comb begin
        ctl_ovr = control_port_in;
        for (int i = N_RULE - 1; i >= 0; i--) begin
            if (state[i] == ST_ACTIVE)
                ctl_ovr = (ctl_ovr & ~ctl_mask[i]) | (ctl_value[i] & ctl_mask[i]);
        end
    end

    assign control_port_out = ctl_ovr;

    // Active flags decoded directly from the registered rule state
    always_comb begin
        rule_active = '0;
        for (int i = 0; i < N_RULE; i++)
            rule_active[i] = (state[i] == ST_ACTIVE);
    end

endmodule

// File: tb/tb_remediation_ctrl_unit.sv
// Testbench for remediation_ctrl_unit: directed scenarios followed by random
// traffic, all compared against a streak/window-based reference model.
module tb_remediation_ctrl_unit;

    localparam int OBS_W  = 40;
    localparam int CTL_W  = 38;
    localparam int N_RULE = 4;
    localparam int CNT_W  = 8;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [OBS_W-1:0]  observe_port;
    logic [CTL_W-1:0]  control_port_in;
    logic [CTL_W-1:0]  control_port_out;
    logic              cfg_we;
    logic              cfg_re;
    logic [7:0]        cfg_addr;
    logic [OBS_W-1:0]  cfg_wdata;
    logic [OBS_W-1:0]  cfg_rdata;
    logic [N_RULE-1:0] rule_active;
    logic              trig_pulse;

    remediation_ctrl_unit #(
        .OBS_W(OBS_W), .CTL_W(CTL_W), .N_RULE(N_RULE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .observe_port(observe_port),
        .control_port_in(control_port_in),
        .control_port_out(control_port_out),
        .cfg_we(cfg_we),
        .cfg_re(cfg_re),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .rule_active(rule_active),
        .trig_pulse(trig_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: configuration plus a streak of consecutive matches and
    // the number of override cycles left (-1 = sticky, 0 = not overriding).
    logic [OBS_W-1:0] m_mm [N_RULE];
    logic [OBS_W-1:0] m_mv [N_RULE];
    logic [CTL_W-1:0] m_cm [N_RULE];
    logic [CTL_W-1:0] m_cv [N_RULE];
    int m_en [N_RULE];
    int m_thr [N_RULE];
    int m_hold [N_RULE];
    int m_cnt [N_RULE];
    int m_streak [N_RULE];
    int m_left [N_RULE];
    logic [OBS_W-1:0] m_rdata;

    int n_assert = 0;
    int n_fail = 0;
    logic [OBS_W-1:0] rd;
    int r, f;
    int pat [6] = '{1, 1, 0, 1, 1, 1};
    int exp_st [6] = '{0, 1, 1, 0, 1, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_RULE; i++) begin
            m_mm[i] = '0; m_mv[i] = '0; m_cm[i] = '0; m_cv[i] = '0;
            m_en[i] = 0; m_thr[i] = 0; m_hold[i] = 0; m_cnt[i] = 0;
            m_streak[i] = 0; m_left[i] = 0;
        end
        m_rdata = '0;
    endfunction

    function automatic bit m_match(int i);
        return (m_en[i] != 0) && ((observe_port & m_mm[i]) == (m_mv[i] & m_mm[i]));
    endfunction

    function automatic bit m_written(int i);
        return cfg_we && (int'(cfg_addr[7:4]) == i) && (int'(cfg_addr[3:0]) <= 4);
    endfunction

    function automatic bit m_fires(int i);
        int te;
        te = (m_thr[i] == 0) ? 1 : m_thr[i];
        return !m_written(i) && (m_left[i] == 0) && m_match(i) && (m_streak[i] + 1 >= te);
    endfunction

    function automatic logic [CTL_W-1:0] m_ctl();
        logic [CTL_W-1:0] v;
        bit found;
        v = control_port_in;
        for (int b = 0; b < CTL_W; b++) begin
            found = 0;
            for (int i = 0; i < N_RULE; i++) begin
                if (!found && (m_left[i] != 0) && m_cm[i][b]) begin
                    v[b] = m_cv[i][b];
                    found = 1;
                end
            end
        end
        return v;
    endfunction

    function automatic logic [OBS_W-1:0] m_read(int rr, int ff);
        if (rr >= N_RULE) return '0;
        case (ff)
            0: return m_mm[rr];
            1: return m_mv[rr];
            2: return OBS_W'(m_cm[rr]);
            3: return OBS_W'(m_cv[rr]);
            4: return (OBS_W'(m_en[rr]) << (2*CNT_W)) | (OBS_W'(m_thr[rr]) << CNT_W) | OBS_W'(m_hold[rr]);
            5: return OBS_W'(m_cnt[rr]);
            6: return (m_left[rr] != 0) ? OBS_W'(2) : ((m_streak[rr] > 0) ? OBS_W'(1) : OBS_W'(0));
            default: return '0;
        endcase
    endfunction

    function automatic void model_step();
        bit fire [N_RULE];
        bit wr [N_RULE];
        bit mt [N_RULE];
        if (rst) begin
            model_reset();
            return;
        end
        if (cfg_re) m_rdata = m_read(int'(cfg_addr[7:4]), int'(cfg_addr[3:0]));
        for (int i = 0; i < N_RULE; i++) begin
            fire[i] = m_fires(i);
            wr[i] = m_written(i);
            mt[i] = m_match(i);
        end
        for (int i = 0; i < N_RULE; i++) begin
            if (wr[i]) begin
                m_streak[i] = 0;
                m_left[i] = 0;
            end else if (m_left[i] != 0) begin
                if (m_left[i] > 0) m_left[i]--;
            end else if (mt[i]) begin
                m_streak[i]++;
                if (fire[i]) begin
                    m_left[i] = (m_hold[i] == 0) ? -1 : m_hold[i];
                    m_streak[i] = 0;
                    if (m_cnt[i] < MAXC) m_cnt[i]++;
                end
            end else begin
                m_streak[i] = 0;
            end
            if (cfg_we && int'(cfg_addr[7:4]) == i) begin
                case (int'(cfg_addr[3:0]))
                    0: m_mm[i] = cfg_wdata;
                    1: m_mv[i] = cfg_wdata;
                    2: m_cm[i] = cfg_wdata[CTL_W-1:0];
                    3: m_cv[i] = cfg_wdata[CTL_W-1:0];
                    4: begin
                        m_en[i]   = int'(cfg_wdata[2*CNT_W]);
                        m_thr[i]  = int'(cfg_wdata[2*CNT_W-1:CNT_W]);
                        m_hold[i] = int'(cfg_wdata[CNT_W-1:0]);
                    end
                    5: m_cnt[i] = 0;
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic check_outputs();
        logic [N_RULE-1:0] ea;
        bit et;
        et = 0;
        for (int i = 0; i < N_RULE; i++) begin
            ea[i] = (m_left[i] != 0);
            if (m_fires(i)) et = 1;
        end
        chk("ctl_out", 64'(control_port_out), 64'(m_ctl()));
        chk("trig", 64'(trig_pulse), 64'(et));
        chk("rule_active", 64'(rule_active), 64'(ea));
        chk("rdata", 64'(cfg_rdata), 64'(m_rdata));
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OBS_W-1:0] f4(int en, int thr, int hold);
        return (OBS_W'(en) << (2*CNT_W)) | (OBS_W'(thr) << CNT_W) | OBS_W'(hold);
    endfunction

    task automatic cfg_write(input int rr, input int ff, input logic [OBS_W-1:0] d);
        cfg_we = 1'b1;
        cfg_addr = {4'(rr), 4'(ff)};
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input int rr, input int ff, output logic [OBS_W-1:0] d);
        cfg_re = 1'b1;
        cfg_addr = {4'(rr), 4'(ff)};
        tick();
        cfg_re = 1'b0;
        d = cfg_rdata;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        observe_port = '0;
        control_port_in = 38'h15_5555_5555;
        model_reset();

        // Reset pass-through
        #2;
        chk("rst_passthru", 64'(control_port_out), 64'(38'h15_5555_5555));
        chk("rst_rule_active", 64'(rule_active), 64'(0));
        chk("rst_rdata", 64'(cfg_rdata), 64'(0));
        chk("rst_trig", 64'(trig_pulse), 64'(0));
        tick(); tick();
        rst = 1'b0;
        tick();

        // Threshold 3, hold 4 on rule0 bit 0
        control_port_in = '1;
        observe_port = OBS_W'(1);
        cfg_write(0, 0, OBS_W'(1));
        cfg_write(0, 1, OBS_W'(1));
        cfg_write(0, 2, OBS_W'(1));
        cfg_write(0, 3, OBS_W'(0));
        cfg_write(0, 4, f4(1, 3, 4));
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) observe_port = '0;
            #1;
            chk("thr3_trig", 64'(trig_pulse), 64'(c == 3));
            chk("thr3_bit0", 64'(control_port_out[0]), 64'(!(c >= 4 && c <= 7)));
            tick();
        end
        cfg_read(0, 5, rd);
        chk("thr3_count", 64'(rd), 64'(1));

        // Broken run 1,1,0,1,1,1 with state readback every cycle
        for (int k = 0; k < 6; k++) begin
            observe_port = OBS_W'(pat[k]);
            cfg_re = 1'b1;
            cfg_addr = {4'd0, 4'd6};
            #1;
            chk("brk_trig", 64'(trig_pulse), 64'(k == 5));
            tick();
            chk("brk_state", 64'(cfg_rdata), 64'(exp_st[k]));
        end
        observe_port = '0;
        tick();
        chk("brk_state_active", 64'(cfg_rdata), 64'(2));
        cfg_re = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        cfg_read(0, 5, rd);
        chk("brk_count", 64'(rd), 64'(2));

        // Priority and sticky: rules 1 and 2 both own bit 5
        control_port_in = '0;
        cfg_write(2, 2, OBS_W'(1) << 5);
        cfg_write(2, 3, OBS_W'(0));
        cfg_write(2, 4, f4(1, 1, 0));
        cfg_write(1, 2, OBS_W'(1) << 5);
        cfg_write(1, 3, OBS_W'(1) << 5);
        cfg_write(1, 4, f4(1, 1, 0));
        tick();
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("prio_bit5", 64'(control_port_out[5]), 64'(1));
            tick();
        end
        control_port_in = '1;
        cfg_write(1, 4, OBS_W'(0));
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sticky_r2_bit5", 64'(control_port_out[5]), 64'(0));
            tick();
        end
        cfg_write(2, 4, OBS_W'(0));
        #1;
        chk("r2_off_bit5", 64'(control_port_out[5]), 64'(1));

        // Saturation of the activation counter and clear-on-write
        cfg_write(3, 4, f4(1, 1, 1));
        for (int k = 0; k < 620; k++) tick();
        cfg_read(3, 5, rd);
        chk("sat_count", 64'(rd), 64'(8'hFF));
        cfg_write(3, 5, OBS_W'(0));
        cfg_read(3, 5, rd);
        chk("sat_cleared", 64'(rd), 64'(0));
        cfg_write(3, 4, OBS_W'(0));

        // Reset while rule0 is overriding
        cfg_write(0, 4, f4(1, 1, 10));
        observe_port = OBS_W'(1);
        tick(); tick();
        #1;
        chk("pre_rst_bit0", 64'(control_port_out[0]), 64'(0));
        chk("pre_rst_active", 64'(rule_active), 64'(1));
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_out", 64'(control_port_out), 64'(control_port_in));
        chk("mid_rst_active", 64'(rule_active), 64'(0));
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("post_rst_active", 64'(rule_active), 64'(0));
            chk("post_rst_trig", 64'(trig_pulse), 64'(0));
            tick();
        end

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            observe_port = OBS_W'({$urandom, $urandom});
            control_port_in = CTL_W'({$urandom, $urandom});
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_re = ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 5));
            f = int'($urandom_range(0, 8));
            cfg_addr = {4'(r), 4'(f)};
            case (f)
                0: cfg_wdata = OBS_W'($urandom_range(0, 15));
                4: cfg_wdata = f4(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 4)),
                                  int'($urandom_range(0, 5)));
                default: cfg_wdata = OBS_W'({$urandom, $urandom});
            endcase
            tick();
        end
        cfg_we = 1'b0;
        cfg_re = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
